// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes, flag bit positions and control bundle
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    typedef struct packed {
        logic cond_ex;
        logic pc_src;
        logic reg_write;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation against current flags
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = !z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = !c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = !n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = !v;
            COND_HI: CondEx = c && !z;
            COND_LS: CondEx = !c || z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = !z && (n == v);
            COND_LE: CondEx = z || (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - registered conditional-execution gating, flag register and skip counter
module cond_logic
    import cond_pkg::*;
#(
    parameter int SKIP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    input  logic [1:0]            FlagW,
    input  logic                  PCS,
    input  logic                  RegW,
    input  logic                  MemW,
    input  logic                  NoWrite,
    input  logic                  skip_clr,
    output logic                  out_valid,
    output logic                  PCSrc,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  CondEx,
    output logic [3:0]            Flags,
    output logic [SKIP_CNT_W-1:0] skip_cnt
);

    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [3:0]            flags_q, flags_d;
    logic [SKIP_CNT_W-1:0] skip_q, skip_d;

    logic accept;
    logic cond_ok;

    assign accept = in_valid && !stall;

    // Evaluated against the registered flags, so an instruction never sees its own update.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ok)
    );

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        flags_d = flags_q;
        skip_d  = skip_q;

        if (!stall) begin
            valid_d = accept;
            ctrl_d  = '0;
        end

        if (accept) begin
            ctrl_d.cond_ex   = cond_ok;
            ctrl_d.pc_src    = PCS && cond_ok;
            ctrl_d.reg_write = RegW && !NoWrite && cond_ok;
            ctrl_d.mem_write = MemW && cond_ok;

            if (cond_ok) begin
                if (FlagW[FLAGW_NZ]) begin
                    flags_d[FLAG_N] = ALUFlags[FLAG_N];
                    flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
                end
                if (FlagW[FLAGW_CV]) begin
                    flags_d[FLAG_C] = ALUFlags[FLAG_C];
                    flags_d[FLAG_V] = ALUFlags[FLAG_V];
                end
            end else if (skip_q != '1) begin
                skip_d = skip_q + SKIP_CNT_W'(1);
            end
        end

        // Clear applies even while stalled and beats a same-edge increment.
        if (skip_clr) begin
            skip_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            flags_q <= 4'b0000;
            skip_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            flags_q <= flags_d;
            skip_q  <= skip_d;
        end
    end

    assign out_valid = valid_q;
    assign CondEx    = ctrl_q.cond_ex;
    assign PCSrc     = ctrl_q.pc_src;
    assign RegWrite  = ctrl_q.reg_write;
    assign MemWrite  = ctrl_q.mem_write;
    assign Flags     = flags_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - randomized scoreboard bench for cond_logic with a behavioural model
module tb_cond_logic;

    // Narrow counter so saturation is reachable in a few hundred cycles.
    localparam int W = 8;
    localparam logic [W-1:0] SKIP_MAX = '1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0, stall = 1'b0;
    logic [3:0]   Cond = 4'h0, ALUFlags = 4'h0;
    logic [1:0]   FlagW = 2'b00;
    logic         PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0, skip_clr = 1'b0;
    logic         out_valid, PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]   Flags;
    logic [W-1:0] skip_cnt;

    cond_logic #(.SKIP_CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .skip_clr(skip_clr), .out_valid(out_valid),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   ctl;   // {out_valid, CondEx, PCSrc, RegWrite, MemWrite}
        logic [3:0]   flags;
        logic [W-1:0] skip;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [4:0]   m_ctl   = '0;
    logic [3:0]   m_flags = '0;
    logic [W-1:0] m_skip  = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Predicate per Cond[3:1]; Cond[0] inverts it, except 1111 which is always true.
    function automatic logic cond_ok(input logic [3:0] cnd, input logic [3:0] f);
        logic n, z, c, v;
        logic [7:0] base;
        {n, z, c, v} = f;
        base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
        if (cnd == 4'hF) return 1'b1;
        return base[cnd[3:1]] ^ cnd[0];
    endfunction

    task automatic step(input logic v, input logic st, input logic [3:0] cnd,
                        input logic [3:0] af, input logic [1:0] fw, input logic pcs_b,
                        input logic rw, input logic mw, input logic nw, input logic clr);
        exp_t e;
        logic ok;
        in_valid = v; stall = st; Cond = cnd; ALUFlags = af; FlagW = fw;
        PCS = pcs_b; RegW = rw; MemW = mw; NoWrite = nw; skip_clr = clr;
        if (!st) begin
            if (v) begin
                ok = cond_ok(cnd, m_flags);
                m_ctl = {1'b1, ok, pcs_b & ok, rw & ~nw & ok, mw & ok};
                if (ok) begin
                    if (fw[1]) m_flags[3:2] = af[3:2];
                    if (fw[0]) m_flags[1:0] = af[1:0];
                end else if (m_skip != SKIP_MAX) begin
                    m_skip = m_skip + 1'b1;
                end
            end else begin
                m_ctl = '0;
            end
        end
        if (clr) m_skip = '0;
        e.ctl = m_ctl; e.flags = m_flags; e.skip = m_skip;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk("async_reset_outputs",
               {19'd0, out_valid, CondEx, PCSrc, RegWrite, MemWrite, Flags, skip_cnt}, 32'd0);
        #1 reset_n = 1'b1;
        m_ctl = '0; m_flags = '0; m_skip = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctl", {27'd0, out_valid, CondEx, PCSrc, RegWrite, MemWrite}, {27'd0, e.ctl});
            chk("flags", {28'd0, Flags}, {28'd0, e.flags});
            chk("skip_cnt", {24'd0, skip_cnt}, {24'd0, e.skip});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 chk("reset_state",
               {19'd0, out_valid, CondEx, PCSrc, RegWrite, MemWrite, Flags, skip_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Overflow-style flag write, then GE/LT against the new flags back to back.
        step(1, 0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        step(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 0, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        // Failed condition must block its own flag write.
        step(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0001, 4'b0000, 2'b11, 1, 1, 1, 0, 0);
        // Partial flag write and NoWrite suppression.
        step(1, 0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        step(1, 0, 4'b1110, 4'b0110, 2'b10, 0, 1, 1, 1, 0);
        // Stall with a failing instruction presented.
        repeat (3) step(1, 1, 4'b0001, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
        step(0, 0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
        // Drive the skip counter into saturation, then clear on a failing accept.
        repeat (int'(SKIP_MAX) + 3) step(1, 0, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 0, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        // Mid-cycle reset with flags all set and a valid output held.
        step(1, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
        step(1, 1, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
        reset_pulse();
        step(1, 0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse();
            step($urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        #1 chk("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter SKIP_CNT_W, default 16, width of the skipped-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  instruction present this cycle.
REQ-005 stall  input  1  hold all state and outputs; overrides in_valid.
REQ-006 Cond  input  4  ARM condition field of the instruction.
REQ-007 ALUFlags  input  4  {N,Z,C,V} from the ALU for this instruction (bit3=N, bit0=V).
REQ-008 FlagW  input  2  flag-write request: bit1 = N,Z; bit0 = C,V.
REQ-009 PCS, RegW, MemW  input  1 each  unconditional write/branch requests from decode.
REQ-010 NoWrite  input  1  suppress RegWrite (compare-type ops).
REQ-011 skip_clr  input  1  synchronous clear of skip counter.
REQ-012 out_valid  output  1  registered outputs below are valid.
REQ-013 PCSrc, RegWrite, MemWrite, CondEx  output  1 each  gated controls, registered.
REQ-014 Flags  output  4  architectural flag register {N,Z,C,V}.
REQ-015 skip_cnt  output  SKIP_CNT_W  count of valid instructions whose condition failed.

Function
REQ-016 Accepted instruction = in_valid=1 and stall=0 at a rising edge.
REQ-017 Condition SHALL be evaluated combinationally against Flags as held before that edge.
REQ-018 Cond decode SHALL be: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 and 1111 true.
REQ-019 On accept, Flags[3:2] SHALL load ALUFlags[3:2] iff FlagW[1]&CondEx; Flags[1:0] SHALL load ALUFlags[1:0] iff FlagW[0]&CondEx; unselected bits hold.
REQ-020 An instruction's own flag write SHALL NOT affect its own condition; the next accepted instruction sees it (back-to-back, zero bubble).
REQ-021 Latency 1: on the edge accepting an instruction, out_valid<=1, CondEx<=cond, PCSrc<=PCS&cond, RegWrite<=RegW&!NoWrite&cond, MemWrite<=MemW&cond.
REQ-022 Edge with stall=0 and in_valid=0: out_valid<=0 and all four control outputs <=0; Flags hold.
REQ-023 Edge with stall=1: every register (outputs, Flags, skip_cnt) holds, except skip_clr which still applies.
REQ-024 skip_cnt SHALL increment by 1 on each accepted instruction with cond false, saturating at all-ones.
REQ-025 skip_clr=1 SHALL set skip_cnt to 0 on the edge, winning over a simultaneous increment.

Reset
REQ-026 reset_n=0 SHALL immediately force out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags and skip_cnt to 0, independent of clk.
REQ-027 Reset asserted mid-stall or mid-stream SHALL discard the in-flight instruction; first accept after release sees Flags=0000.
REQ-028 Reset deassertion SHALL take effect at the first rising edge with reset_n=1; no other input is sampled while reset_n=0.

Structure
REQ-029 Shared package cond_pkg SHALL hold: cond_e enum of the 16 codes, localparams FLAG_N=3/Z=2/C=1/V=0, FLAGW_NZ=1/FLAGW_CV=0.
REQ-030 Combinational sub-module cond_check (inputs Cond, Flags; output CondEx) SHALL implement REQ-018; cond_logic owns all registers.

Verification
REQ-031 Reset, then Cond=1110, FlagW=11, ALUFlags=1001 (0x7FFFFFFF+1) -> next cycle Flags=1001, CondEx=1, out_valid=1.
REQ-032 Following back-to-back instruction Cond=1010 (GE), RegW=1 -> CondEx=1, RegWrite=1; Cond=1011 (LT) instead -> CondEx=0, RegWrite=0, skip_cnt=1.
REQ-033 Flags=0100, instruction Cond=0001 (NE), FlagW=11, ALUFlags=0000 -> CondEx=0, Flags stay 0100 (failed condition blocks flag write).
REQ-034 FlagW=10 with ALUFlags=0110 from Flags=1001 -> Flags=0101 (only N,Z replaced); MemW=1, NoWrite=1, RegW=1, Cond=1110 -> MemWrite=1, RegWrite=0.
REQ-035 stall=1 for 3 cycles with in_valid=1 and failing Cond -> outputs, Flags, skip_cnt unchanged; skip_cnt at 0xFFFF plus one failing accept -> stays 0xFFFF; skip_clr with failing accept -> 0.
REQ-036 reset_n pulsed low between clock edges with Flags=1111, out_valid=1 -> all outputs 0 before next edge; next accepted Cond=0000 -> CondEx=0.
